// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller signal bundle; perf counter outputs exist only with HAZARD_PERF_EN.
interface hazard_ctrl_if;
  logic [4:0]  rsD, rtD, rsE, rtE;
  logic [4:0]  writeRegE, writeRegM, writeRegW;
  logic        regWriteE, regWriteM, regWriteW;
  logic        memToRegE, memToRegM;
  logic        branchD, pcSrcD, jumpD, mdStartE;
  logic        stallF, stallD, stallE;
  logic        flushD, flushE, flushM;
  logic        forwardAD, forwardBD;
  logic [1:0]  forwardAE, forwardBE;
  logic        mdBusy;
`ifdef HAZARD_PERF_EN
  logic [31:0] stallCycles, lwStallCount, mdStallCount;
`endif

  modport slave (
    input  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
           regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
           branchD, pcSrcD, jumpD, mdStartE,
    output stallF, stallD, stallE, flushD, flushE, flushM,
           forwardAD, forwardBD, forwardAE, forwardBE, mdBusy
`ifdef HAZARD_PERF_EN
    , output stallCycles, lwStallCount, mdStallCount
`endif
  );

  modport master (
    output rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
           regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
           branchD, pcSrcD, jumpD, mdStartE,
    input  stallF, stallD, stallE, flushD, flushE, flushM,
           forwardAD, forwardBD, forwardAE, forwardBE, mdBusy
`ifdef HAZARD_PERF_EN
    , input stallCycles, lwStallCount, mdStallCount
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage MIPS hazard unit: forwarding, load-use/branch stalls, mult/div hold FSM.
// Optional stall statistics counters are enabled by HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   hz
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               md_stall, lw_stall, br_stall, any_stall;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  always_comb begin
    hz.forwardAE = 2'b00;
    if (hz.regWriteM && hit(hz.rsE, hz.writeRegM))      hz.forwardAE = 2'b10;
    else if (hz.regWriteW && hit(hz.rsE, hz.writeRegW)) hz.forwardAE = 2'b01;
    hz.forwardBE = 2'b00;
    if (hz.regWriteM && hit(hz.rtE, hz.writeRegM))      hz.forwardBE = 2'b10;
    else if (hz.regWriteW && hit(hz.rtE, hz.writeRegW)) hz.forwardBE = 2'b01;
  end

  assign hz.forwardAD = hz.regWriteM && hit(hz.rsD, hz.writeRegM);
  assign hz.forwardBD = hz.regWriteM && hit(hz.rtD, hz.writeRegM);

  assign lw_stall = hz.memToRegE && (hit(hz.rtE, hz.rsD) || hit(hz.rtE, hz.rtD));
  assign br_stall = hz.branchD &&
      ((hz.regWriteE && (hit(hz.writeRegE, hz.rsD) || hit(hz.writeRegE, hz.rtD))) ||
       (hz.memToRegM && (hit(hz.writeRegM, hz.rsD) || hit(hz.writeRegM, hz.rtD))));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The stall covers the entry cycle plus MD_LATENCY-2 busy cycles; the last busy cycle releases.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (hz.mdStartE) begin
          md_stall = 1'b1;
          state_d  = BUSY;
          cnt_d    = CNT_W'(MD_LATENCY - 2);
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          md_stall = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall/flush outputs are gated by reset so they drop without waiting for a clock.
  assign any_stall = rst & (lw_stall | br_stall | md_stall);
  assign hz.stallF = any_stall;
  assign hz.stallD = any_stall;
  assign hz.stallE = rst & md_stall;
  assign hz.flushM = rst & md_stall;
  assign hz.flushE = rst & (lw_stall | br_stall) & ~md_stall;
  assign hz.flushD = rst & (hz.pcSrcD | hz.jumpD) & ~any_stall;
  assign hz.mdBusy = (state_q == BUSY);

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, lw_count_q, md_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      lw_count_q     <= '0;
      md_count_q     <= '0;
    end else begin
      if (any_stall && stall_cycles_q != 32'hFFFF_FFFF) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (lw_stall && lw_count_q != 32'hFFFF_FFFF)      lw_count_q     <= lw_count_q + 32'd1;
      if (state_q == IDLE && state_d == BUSY && md_count_q != 32'hFFFF_FFFF)
        md_count_q <= md_count_q + 32'd1;
    end
  end

  assign hz.stallCycles  = stall_cycles_q;
  assign hz.lwStallCount = lw_count_q;
  assign hz.mdStallCount = md_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector table plus mult/div, overlap and reset sequences for hazard_ctrl.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  hazard_ctrl_if hif ();
  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .hz(hif));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic        regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
    logic        branchD, pcSrcD, jumpD;
    // {stallF,stallD,stallE, flushD,flushE,flushM, fwdAD,fwdBD, fwdAE, fwdBE, mdBusy}
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [12:0] NONE  = 13'b000_000_00_00_00_0;
  localparam logic [12:0] LUST  = 13'b110_010_00_00_00_0;
  localparam logic [12:0] MDS   = 13'b111_001_00_00_00_0;
  localparam logic [12:0] MDSB  = 13'b111_001_00_00_00_1;
  localparam logic [12:0] BUSYF = 13'b000_000_00_00_00_1;

  task automatic clear_inputs();
    hif.rsD = 0; hif.rtD = 0; hif.rsE = 0; hif.rtE = 0;
    hif.writeRegE = 0; hif.writeRegM = 0; hif.writeRegW = 0;
    hif.regWriteE = 0; hif.regWriteM = 0; hif.regWriteW = 0;
    hif.memToRegE = 0; hif.memToRegM = 0;
    hif.branchD = 0; hif.pcSrcD = 0; hif.jumpD = 0; hif.mdStartE = 0;
  endtask

  task automatic apply(input vec_t v);
    hif.rsD = v.rsD; hif.rtD = v.rtD; hif.rsE = v.rsE; hif.rtE = v.rtE;
    hif.writeRegE = v.writeRegE; hif.writeRegM = v.writeRegM; hif.writeRegW = v.writeRegW;
    hif.regWriteE = v.regWriteE; hif.regWriteM = v.regWriteM; hif.regWriteW = v.regWriteW;
    hif.memToRegE = v.memToRegE; hif.memToRegM = v.memToRegM;
    hif.branchD = v.branchD; hif.pcSrcD = v.pcSrcD; hif.jumpD = v.jumpD;
    hif.mdStartE = 1'b0;
  endtask

  task automatic chk(input string name, input logic [12:0] exp);
    logic [12:0] got;
    got = {hif.stallF, hif.stallD, hif.stallE, hif.flushD, hif.flushE, hif.flushM,
           hif.forwardAD, hif.forwardBD, hif.forwardAE, hif.forwardBE, hif.mdBusy};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic step_chk(input string name, input logic [12:0] exp);
    @(negedge clk);
    #1 chk(name, exp);
  endtask

  initial begin
    vecs.push_back('{default:'0, exp:NONE});
    vecs.push_back('{default:'0, memToRegE:1, rtE:5, rsD:5, exp:LUST});
    vecs.push_back('{default:'0, memToRegE:1, exp:NONE});
    vecs.push_back('{default:'0, memToRegE:1, rtE:7, rtD:7, rsD:2, exp:LUST});
    vecs.push_back('{default:'0, regWriteM:1, writeRegM:8, regWriteW:1, writeRegW:8, rsE:8,
                     exp:13'b000_000_00_10_00_0});
    vecs.push_back('{default:'0, writeRegM:8, regWriteW:1, writeRegW:8, rsE:8,
                     exp:13'b000_000_00_01_00_0});
    vecs.push_back('{default:'0, regWriteM:1, regWriteW:1, exp:NONE});
    vecs.push_back('{default:'0, regWriteM:1, writeRegM:9, regWriteW:1, writeRegW:9, rtE:9,
                     exp:13'b000_000_00_00_10_0});
    vecs.push_back('{default:'0, regWriteM:1, writeRegM:4, regWriteW:1, writeRegW:9, rsE:9, rtE:4,
                     exp:13'b000_000_00_01_10_0});
    vecs.push_back('{default:'0, branchD:1, rsD:3, regWriteE:1, writeRegE:3, exp:LUST});
    vecs.push_back('{default:'0, branchD:1, rsD:3, regWriteM:1, writeRegM:3,
                     exp:13'b000_000_10_00_00_0});
    vecs.push_back('{default:'0, branchD:1, rsD:3, regWriteM:1, writeRegM:3, pcSrcD:1,
                     exp:13'b000_100_10_00_00_0});
    vecs.push_back('{default:'0, branchD:1, rtD:4, regWriteM:1, memToRegM:1, writeRegM:4,
                     exp:13'b110_010_01_00_00_0});
    vecs.push_back('{default:'0, memToRegE:1, rtE:5, rsD:5, jumpD:1, exp:LUST});
    vecs.push_back('{default:'0, jumpD:1, exp:13'b000_100_00_00_00_0});
    vecs.push_back('{default:'0, branchD:1, regWriteE:1, memToRegM:1, exp:NONE});
    vecs.push_back('{default:'0, rsD:3, regWriteE:1, writeRegE:3, exp:NONE});

    // Reset: stalls forced low even with a mult/div start, forwarding still live.
    clear_inputs();
    hif.mdStartE = 1'b1; hif.regWriteM = 1'b1; hif.writeRegM = 5'd8; hif.rsE = 5'd8;
    #1 chk("reset_state", 13'b000_000_00_10_00_0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1 chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Mult/div back-to-back: stall 1-3, release on 4, second op stalls 5-7.
    @(negedge clk);
    clear_inputs();
    hif.mdStartE = 1'b1;
    #1 chk("md_c1", MDS);
    step_chk("md_c2", MDSB);
    step_chk("md_c3", MDSB);
    step_chk("md_c4", BUSYF);
    step_chk("md_b2b_c1", MDS);
    step_chk("md_b2b_c2", MDSB);
    step_chk("md_b2b_c3", MDSB);
    step_chk("md_b2b_c4", BUSYF);
    @(negedge clk);
    hif.mdStartE = 1'b0;
    #1 chk("md_idle", NONE);

    // Load-use and redirect during BUSY: Execute held, redirect deferred.
    @(negedge clk);
    hif.mdStartE = 1'b1;
    #1 chk("ovl_c1", MDS);
    @(negedge clk);
    hif.memToRegE = 1'b1; hif.rtE = 5'd6; hif.rsD = 5'd6; hif.pcSrcD = 1'b1;
    #1 chk("ovl_c2", MDSB);
    step_chk("ovl_c3", MDSB);
    step_chk("ovl_c4", 13'b110_010_00_00_00_1);
    @(negedge clk);
    hif.mdStartE = 1'b0; hif.memToRegE = 1'b0;
    #1 chk("ovl_redirect", 13'b000_100_00_00_00_0);

    // Reset asserted mid-BUSY with cnt=1, then a full restart.
    @(negedge clk);
    clear_inputs();
    hif.mdStartE = 1'b1;
    #1 chk("rst_c1", MDS);
    step_chk("rst_c2", MDSB);
    step_chk("rst_c3", MDSB);
    #2 rst = 1'b0;
    #1 chk("rst_async", NONE);
    step_chk("rst_hold", NONE);
    rst = 1'b1;
    #1 chk("rst_re_c1", MDS);
    step_chk("rst_re_c2", MDSB);
    step_chk("rst_re_c3", MDSB);
    step_chk("rst_re_c4", BUSYF);
    @(negedge clk);
    hif.mdStartE = 1'b0;
    #1 chk("rst_re_idle", NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Generates the fetch stall that holds the PC register, plus decode/execute stalls, flushes and forwarding selects.
- Combinational detection of load-use, branch-compare and data-forward hazards.
- Sequential FSM/counter that holds the pipeline while a multi-cycle multiply/divide occupies Execute.

Parameters:
- MD_LATENCY, 4, total cycles a mult/div instruction occupies Execute; legal range 2..16.
- CNT_W, 4, width of the mult/div cycle counter; must satisfy 2^CNT_W > MD_LATENCY.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- rsD, rtD  in  5  source registers of the Decode instruction
- rsE, rtE  in  5  source registers of the Execute instruction
- writeRegE, writeRegM, writeRegW  in  5  destination register in Execute, Memory, Writeback
- regWriteE, regWriteM, regWriteW  in  1  register-write enable per stage
- memToRegE, memToRegM  in  1  load instruction in Execute, Memory
- branchD  in  1  branch instruction in Decode
- pcSrcD  in  1  branch taken, resolved in Decode
- jumpD  in  1  jump instruction in Decode
- mdStartE  in  1  mult/div instruction present in Execute
- stallF, stallD, stallE  out  1  hold the Fetch (PC), Decode, Execute registers
- flushD, flushE, flushM  out  1  clear the Decode, Execute, Memory registers
- forwardAD, forwardBD  out  1  Decode comparator forward from Memory
- forwardAE, forwardBE  out  2  Execute operand select: 00 = reg file, 01 = Writeback, 10 = Memory
- mdBusy  out  1  FSM in BUSY

Behaviour:
- Reset (rst low): state=IDLE, cnt=0. All stall/flush outputs and mdBusy forced 0. Forward selects remain combinational.
- Register 0 never matches: every comparison below requires the register field to be nonzero.
- forwardAE: 10 if regWriteM && writeRegM==rsE; else 01 if regWriteW && writeRegW==rsE; else 00. Memory has priority over Writeback. forwardBE is the same using rtE.
- forwardAD = regWriteM && writeRegM==rsD. forwardBD is the same using rtD.
- lwStall = memToRegE && (rtE==rsD || rtE==rtD).
- brStall = branchD && ((regWriteE && writeRegE in {rsD,rtD}) || (memToRegM && writeRegM in {rsD,rtD})).
- FSM states: IDLE and BUSY.
  - IDLE with mdStartE=1: mdStall=1; next state BUSY, cnt<=MD_LATENCY-2.
  - BUSY with cnt!=0: mdStall=1; cnt<=cnt-1.
  - BUSY with cnt==0: mdStall=0; next state IDLE, and the op leaves Execute.
  - mdStartE is ignored in BUSY.
  - Back-to-back mult/div: a second op entering Execute right after exit restarts from IDLE.
- Result: mdStall is high for exactly MD_LATENCY-1 consecutive cycles per op.
- Output equations:
  - stallF = stallD = lwStall | brStall | mdStall
  - stallE = mdStall; flushM = mdStall (bubble into Memory)
  - flushE = (lwStall | brStall) & ~mdStall. Execute is held, not cleared, during mult/div.
  - flushD = (pcSrcD | jumpD) & ~stallD. A redirect under stall is deferred until the stall clears.
- Reset asserted mid-BUSY: immediate return to IDLE, cnt=0, stalls drop asynchronously.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds three outputs: stallCycles [31:0], lwStallCount [31:0], mdStallCount [31:0].
  - stallCycles increments every cycle stallF=1.
  - lwStallCount increments on each cycle lwStall=1.
  - mdStallCount increments on each IDLE->BUSY transition.
  - All saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Load-use: memToRegE=1, rtE=5, rsD=5 -> stallF=stallD=flushE=1 for one cycle, stallE=0. Same with rtE=0 -> no stall.
- Forwarding: regWriteM=1, writeRegM=8, regWriteW=1, writeRegW=8, rsE=8 -> forwardAE=10. Drop regWriteM -> 01. rsE=0 -> 00.
- Branch hazard: branchD=1, rsD=3, regWriteE=1, writeRegE=3 -> stall+flushE. Next cycle, same reg now in Memory via ALU op -> no stall, forwardAD=1. Then pcSrcD=1 -> flushD=1.
- Mult/div with MD_LATENCY=4: mdStartE pulse -> stallF/stallD/stallE/flushM high for 3 cycles, mdBusy high for cycles 2-4, released on cycle 4. Back-to-back op -> second 3-cycle stall with no gap bubble.
- Simultaneous events: load-use during BUSY -> flushE=0, stallE=1. pcSrcD during stall -> flushD=0 until stall clears.
- Reset: rst low during BUSY cnt=1 -> all stalls 0 immediately, mdBusy=0. After release, mdStartE restarts a full MD_LATENCY-1 stall.
